// File: rtl/reg_mac_pkg.sv
// Shared types and register-map constants for the reg_mac register-bus accelerator.
package reg_mac_pkg;

  // Operation selected by CTRL.mode; RSVD is rejected at start time.
  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_MUL  = 2'd1,
    MODE_MAC  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Engine state; MUL and MAC share the multiplier state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  // Register word indices (byte offset = index * DATA_WIDTH/8).
  localparam int CTRL_IDX         = 0;
  localparam int STATUS_IDX       = 1;
  localparam int RES_LO_IDX       = 2;
  localparam int RES_HI_IDX       = 3;
  localparam int CYCLES_IDX       = 4;
  localparam int OPERAND_BASE_IDX = 8;

  // CTRL / STATUS bit positions.
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_MODE_LSB   = 1;
  localparam int CTRL_IRQ_EN_BIT = 3;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;

  // Default bus types for the 32-bit address / 32-bit data configuration.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_mac_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_mac_rsp_t;

endpackage

// File: rtl/reg_mac_seq_mult.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, DATA_WIDTH cycles.
// done is high during the final busy cycle, when product already holds the full result,
// so the owner can capture it on the same edge the multiplier goes idle.
module reg_mac_seq_mult #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] mcand;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] partial;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CW-1:0]           cnt;

  assign partial = mplier[0] ? mcand : '0;
  assign product = acc + partial;
  assign done    = busy && (cnt == CW'(DATA_WIDTH - 1));

  // Load operands on start, then accumulate one shifted partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{DATA_WIDTH{1'b0}}, op_a};
      mplier <= op_b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_mac_regfile.sv
// Register-bus slave with an operand bank, CTRL/STATUS registers and a multi-cycle
// SUM / MUL / MAC engine. Bus responses are combinational and always ready.
module reg_mac_regfile
  import reg_mac_pkg::*;
#(
  parameter int  DATA_WIDTH    = 32,
  parameter int  ADDR_WIDTH    = 32,
  parameter int  NUM_OPERANDS  = 4,
  parameter int  REG_ADDR_BITS = 8,
  parameter type reg_req_t     = reg_mac_pkg::reg_mac_req_t,
  parameter type reg_rsp_t     = reg_mac_pkg::reg_mac_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output logic     irq_o
);

  localparam int S     = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(S);
  localparam int IDX_W = REG_ADDR_BITS - LSB;
  localparam int OP_W  = $clog2(NUM_OPERANDS);
  localparam int CNT_W = 8;
  localparam int AW    = ADDR_WIDTH;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("reg_mac_regfile: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_OPERANDS < 2 || NUM_OPERANDS > 16) begin : g_bad_ops
    $error("reg_mac_regfile: NUM_OPERANDS must be 2..16");
  end
  if ((8 + NUM_OPERANDS) * S > 2 ** REG_ADDR_BITS) begin : g_bad_map
    $error("reg_mac_regfile: register map does not fit in REG_ADDR_BITS");
  end

  // Architectural state
  logic [DATA_WIDTH-1:0]   operand [NUM_OPERANDS];
  mode_e                   mode;
  logic                    irq_en;
  logic                    done;
  logic [2*DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0]   cycles;
  state_e                  state;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  // Decode
  logic [REG_ADDR_BITS-1:0] off;
  logic [IDX_W-1:0]         idx;
  logic [OP_W-1:0]          op_idx;
  logic misaligned, mapped, busy;
  logic sel_ctrl, sel_status, sel_lo, sel_hi, sel_cyc, sel_op;
  logic wr, rd, start_req, error, accept, start_acc;
  mode_e new_mode;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [S-1:0]            wstrb;
  logic [2*DATA_WIDTH-1:0] sum_next;
  logic mult_start, mult_busy, mult_done;
  logic [2*DATA_WIDTH-1:0] product;
  logic unused_addr;

  // Upper address bits are deliberately not decoded.
  assign unused_addr = ^reg_req_i.addr[AW-1:0];

  assign wdata      = reg_req_i.wdata;
  assign wstrb      = reg_req_i.wstrb;
  assign off        = reg_req_i.addr[REG_ADDR_BITS-1:0];
  assign idx        = off[REG_ADDR_BITS-1:LSB];
  assign op_idx     = OP_W'(idx - IDX_W'(OPERAND_BASE_IDX));
  assign misaligned = |off[LSB-1:0];
  assign busy       = (state != ST_IDLE);

  assign sel_ctrl   = (idx == IDX_W'(CTRL_IDX));
  assign sel_status = (idx == IDX_W'(STATUS_IDX));
  assign sel_lo     = (idx == IDX_W'(RES_LO_IDX));
  assign sel_hi     = (idx == IDX_W'(RES_HI_IDX));
  assign sel_cyc    = (idx == IDX_W'(CYCLES_IDX));
  assign sel_op     = (idx >= IDX_W'(OPERAND_BASE_IDX)) &&
                      (idx <  IDX_W'(OPERAND_BASE_IDX + NUM_OPERANDS));
  assign mapped     = sel_ctrl | sel_status | sel_lo | sel_hi | sel_cyc | sel_op;

  assign wr = reg_req_i.valid &  reg_req_i.write;
  assign rd = reg_req_i.valid & !reg_req_i.write;

  // CTRL lives entirely in byte 0, so only wstrb[0] can change mode or start.
  assign new_mode  = wstrb[0] ? mode_e'(wdata[CTRL_MODE_LSB +: 2]) : mode;
  assign start_req = wr & sel_ctrl & wstrb[0] & wdata[CTRL_START_BIT];

  assign error = reg_req_i.valid & (!mapped | misaligned |
                 (wr & (sel_lo | sel_hi | sel_cyc)) |
                 (wr & busy & (sel_ctrl | sel_op)) |
                 (start_req & (new_mode == MODE_RSVD)));

  assign accept     = wr & !error;
  assign start_acc  = accept & start_req;
  assign mult_start = start_acc & (new_mode != MODE_SUM);
  assign sum_next   = acc + {{DATA_WIDTH{1'b0}}, operand[OP_W'(cnt)]};
  assign irq_o      = done & irq_en;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [S-1:0]          strb
  );
    merge_bytes = old_val;
    for (int b = 0; b < S; b++) begin
      if (strb[b]) merge_bytes[b*8 +: 8] = new_val[b*8 +: 8];
    end
  endfunction

  // Read mux: data only for accepted reads, zero otherwise.
  always_comb begin
    rdata = '0;
    if (rd && !error) begin
      if (sel_ctrl) begin
        rdata[CTRL_MODE_LSB +: 2] = mode;
        rdata[CTRL_IRQ_EN_BIT]    = irq_en;
      end
      if (sel_status) begin
        rdata[STAT_BUSY_BIT] = busy;
        rdata[STAT_DONE_BIT] = done;
      end
      if (sel_lo)  rdata = result[DATA_WIDTH-1:0];
      if (sel_hi)  rdata = result[2*DATA_WIDTH-1:DATA_WIDTH];
      if (sel_cyc) rdata = cycles;
      if (sel_op)  rdata = operand[op_idx];
    end
  end

  // Response packing.
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.rdata = rdata;
    reg_rsp_o.error = error;
    reg_rsp_o.ready = 1'b1;
  end

  reg_mac_seq_mult #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mult (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (mult_start),
    .op_a    (operand[0]),
    .op_b    (operand[1]),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (product)
  );

  // Register writes and engine FSM; later assignments to done take priority
  // so a completing operation wins over a same-cycle W1C.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_OPERANDS; i++) operand[i] <= '0;
      mode   <= MODE_SUM;
      irq_en <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cycles <= '0;
      acc    <= '0;
      cnt    <= '0;
      state  <= ST_IDLE;
    end else begin
      if (accept && sel_op) operand[op_idx] <= merge_bytes(operand[op_idx], wdata, wstrb);
      if (accept && sel_ctrl && wstrb[0]) begin
        mode   <= new_mode;
        irq_en <= wdata[CTRL_IRQ_EN_BIT];
      end
      if (accept && sel_status && wstrb[0] && wdata[STAT_DONE_BIT]) done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            done  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            state <= (new_mode == MODE_SUM) ? ST_SUM : ST_MUL;
          end
        end
        ST_SUM: begin
          acc <= sum_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NUM_OPERANDS - 1)) begin
            result <= sum_next;
            cycles <= {{(DATA_WIDTH-CNT_W){1'b0}}, cnt + CNT_W'(1)};
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_MUL: begin
          cnt <= cnt + CNT_W'(1);
          if (mult_done) begin
            result <= (mode == MODE_MAC) ? (result + product) : product;
            cycles <= {{(DATA_WIDTH-CNT_W){1'b0}}, cnt + CNT_W'(1)};
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_mult_busy;
  assign unused_mult_busy = mult_busy;

endmodule
